// File: rtl/ps2_move_decoder.sv
// PS/2 set-2 scan-code parser feeding a small direction FIFO plus a start-key pulse.
// Optional typematic-repeat filtering is enabled with `define PS2_MOVE_REPEAT_FILTER_EN.
module ps2_move_decoder #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ps2_key_pressed,
  input  logic [7:0]    ps2_key_data,
  input  logic          flush,
  input  logic          move_ready,
  output logic          move_valid,
  output logic [1:0]    move_dir,
  output logic          start_pulse,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  // Result layout: {dir_hit, dir[1:0], start_hit}.
  function automatic logic [3:0] decode_key(input logic [7:0] code, input logic ext);
    logic [3:0] r;
    r = 4'b0000;
    if (ext) begin
      case (code)
        8'h75:   r = 4'b1000;
        8'h72:   r = 4'b1010;
        8'h6B:   r = 4'b1100;
        8'h74:   r = 4'b1110;
        8'h5A:   r = 4'b0001;
        default: r = 4'b0000;
      endcase
    end else begin
      case (code)
        8'h1D:   r = 4'b1000;
        8'h1B:   r = 4'b1010;
        8'h1C:   r = 4'b1100;
        8'h23:   r = 4'b1110;
        8'h5A:   r = 4'b0001;
        8'h29:   r = 4'b0001;
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic [1:0]       dir_q, dir_d;
`ifdef PS2_MOVE_REPEAT_FILTER_EN
  logic [4:0]       held_q, held_d;
  logic [3:0]       dir_oh;
`endif

  logic             completed;
  logic             is_make;
  logic             code_ext;
  logic [3:0]       key;
  logic             dir_hit;
  logic             start_hit;
  logic             push_req;
  logic             start_req;
  logic             pop;
  logic             full;
  logic             push_acc;
  logic             drop;

  // Parser, repeat filter and FIFO next-state logic.
  always_comb begin
    state_d   = state_q;
    completed = 1'b0;
    is_make   = 1'b0;
    code_ext  = 1'b0;

    if (ps2_key_pressed) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_key_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (ps2_key_data == 8'hF0) begin
            state_d = S_BRK;
          end else begin
            completed = 1'b1;
            is_make   = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_EXT: begin
          if (ps2_key_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (ps2_key_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            completed = 1'b1;
            is_make   = 1'b1;
            code_ext  = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_BRK: begin
          if (ps2_key_data == 8'hF0) begin
            state_d = S_BRK;
          end else begin
            completed = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (ps2_key_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            completed = 1'b1;
            code_ext  = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    key       = decode_key(ps2_key_data, code_ext);
    dir_hit   = completed & key[3];
    start_hit = completed & key[0];

`ifdef PS2_MOVE_REPEAT_FILTER_EN
    // Held bits suppress typematic repeats until the matching break arrives.
    dir_oh    = 4'b0001 << key[2:1];
    push_req  = 1'b0;
    start_req = 1'b0;
    held_d    = held_q;
    if (dir_hit) begin
      if (is_make) begin
        push_req    = ~|(held_q[3:0] & dir_oh);
        held_d[3:0] = held_q[3:0] | dir_oh;
      end else begin
        held_d[3:0] = held_q[3:0] & ~dir_oh;
      end
    end else if (start_hit) begin
      if (is_make) begin
        start_req = ~held_q[4];
        held_d[4] = 1'b1;
      end else begin
        held_d[4] = 1'b0;
      end
    end else begin
      held_d = held_q;
    end
`else
    push_req  = dir_hit & is_make;
    start_req = start_hit & is_make;
`endif

    pop      = (count_q != CW'(0)) & move_ready;
    full     = (count_q == CW'(DEPTH));
    push_acc = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    mem_d = mem_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = key[2:1];
    end else begin
      mem_d = mem_q;
    end

    wr_ptr_d   = push_acc ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    overflow_d = overflow_q | drop;
    start_d    = start_req;

    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over everything, including a coincident byte.
    if (flush) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      start_d    = 1'b0;
`ifdef PS2_MOVE_REPEAT_FILTER_EN
      held_d     = 5'b00000;
`endif
    end else begin
      state_d = state_d;
    end

    valid_d = (count_d != CW'(0));
    dir_d   = valid_d ? mem_d[rd_ptr_d] : 2'b00;
  end

  // State, storage and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      dir_q      <= 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
`ifdef PS2_MOVE_REPEAT_FILTER_EN
      held_q     <= 5'b00000;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
`ifdef PS2_MOVE_REPEAT_FILTER_EN
      held_q     <= held_d;
`endif
    end
  end

  assign move_valid  = valid_q;
  assign move_dir    = dir_q;
  assign start_pulse = start_q;
  assign overflow    = overflow_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder with a scoreboard queue of expected FIFO entries.
module tb_ps2_move_decoder;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef PS2_MOVE_REPEAT_FILTER_EN
  localparam bit FLT = 1'b1;
`else
  localparam bit FLT = 1'b0;
`endif

  logic          clk;
  logic          resetn;
  logic          ps2_key_pressed;
  logic [7:0]    ps2_key_data;
  logic          flush;
  logic          move_ready;
  logic          move_valid;
  logic [1:0]    move_dir;
  logic          start_pulse;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  int            checks;
  int            errors;
  logic [1:0]    sb[$];
  logic          exp_ovf;

  ps2_move_decoder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .flush           (flush),
    .move_ready      (move_ready),
    .move_valid      (move_valid),
    .move_dir        (move_dir),
    .start_pulse     (start_pulse),
    .overflow        (overflow),
    .fifo_count      (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard pop/flush at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [1:0] exp_dir;
    @(negedge clk);
    if (flush) begin
      sb.delete();
      exp_ovf = 1'b0;
    end else if (move_valid && move_ready) begin
      exp_dir = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
      chk("pop_dir", {6'd0, move_dir}, {6'd0, exp_dir});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit push, input logic [1:0] d);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    if (push && !flush) begin
      if (sb.size() < DEPTH || (move_valid && move_ready)) sb.push_back(d);
      else exp_ovf = 1'b1;
    end
    tick();
    ps2_key_pressed = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; exp_ovf = 1'b0;
    resetn = 1'b0; ps2_key_pressed = 1'b0; ps2_key_data = 8'h00;
    flush = 1'b0; move_ready = 1'b0;
    #12;
    chk("rst_valid", {7'd0, move_valid}, 8'h00);
    chk("rst_dir", {6'd0, move_dir}, 8'h00);
    chk("rst_start", {7'd0, start_pulse}, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);
    chk("rst_count", {5'd0, fifo_count}, 8'h00);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();

    // Make then break of W with the consumer ready.
    move_ready = 1'b1;
    send(8'h1D, 1'b1, 2'b00);
    chk("t1_valid_hi", {7'd0, move_valid}, 8'h01);
    send(8'hF0, 1'b0, 2'b00);
    chk("t1_valid_lo", {7'd0, move_valid}, 8'h00);
    send(8'h1D, 1'b0, 2'b00);
    chk("t1_count", {5'd0, fifo_count}, 8'h00);
    move_ready = 1'b0;

    // Extended right make, right break, left make.
    send(8'hE0, 1'b0, 2'b00); send(8'h74, 1'b1, 2'b11);
    send(8'hE0, 1'b0, 2'b00); send(8'hF0, 1'b0, 2'b00); send(8'h74, 1'b0, 2'b00);
    send(8'hE0, 1'b0, 2'b00); send(8'h6B, 1'b1, 2'b10);
    chk("t2_count", {5'd0, fifo_count}, 8'h02);
    chk("t2_head", {6'd0, move_dir}, 8'h03);
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    chk("t2_head2", {6'd0, move_dir}, 8'h02);
    chk("t2_count2", {5'd0, fifo_count}, 8'h01);
    send(8'h12, 1'b0, 2'b00);
    chk("t2_unrec", {5'd0, fifo_count}, 8'h01);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_flush", {5'd0, fifo_count}, 8'h00);

    // Fill past capacity, then simultaneous push and pop while full.
    send(8'h1C, 1'b1, 2'b10); send(8'h23, 1'b1, 2'b11);
    send(8'h1B, 1'b1, 2'b01); send(8'h1D, 1'b1, 2'b00);
    send(8'h1C, !FLT, 2'b10); send(8'h23, !FLT, 2'b11);
    chk("t3_count", {5'd0, fifo_count}, 8'(sb.size()));
    chk("t3_ovf", {7'd0, overflow}, {7'd0, exp_ovf});
    chk("t3_head", {6'd0, move_dir}, 8'h02);
    move_ready = 1'b1;
    send(8'h1B, !FLT, 2'b01);
    move_ready = 1'b0;
    chk("t3_full_pp", {5'd0, fifo_count}, 8'(sb.size()));
    chk("t3_ovf_keep", {7'd0, overflow}, {7'd0, exp_ovf});
    move_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    move_ready = 1'b0;
    chk("t3_drained", {5'd0, fifo_count}, 8'h00);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_ovf_clr", {7'd0, overflow}, 8'h00);
    chk("t3_valid", {7'd0, move_valid}, 8'h00);
    flush = 1'b1; send(8'h1D, 1'b1, 2'b00); flush = 1'b0;
    chk("t3_flush_byte", {5'd0, fifo_count}, 8'h00);
    flush = 1'b1; send(8'h5A, 1'b0, 2'b00); flush = 1'b0;
    chk("t3_flush_start", {7'd0, start_pulse}, 8'h00);

    // Start keys: plain Enter, keypad Enter, Space.
    send(8'h5A, 1'b0, 2'b00);
    chk("t4_start1", {7'd0, start_pulse}, 8'h01);
    tick();
    chk("t4_start1_lo", {7'd0, start_pulse}, 8'h00);
    send(8'hF0, 1'b0, 2'b00); send(8'h5A, 1'b0, 2'b00);
    chk("t4_brk", {7'd0, start_pulse}, 8'h00);
    send(8'hE0, 1'b0, 2'b00); send(8'h5A, 1'b0, 2'b00);
    chk("t4_start2", {7'd0, start_pulse}, 8'h01);
    tick();
    chk("t4_start2_lo", {7'd0, start_pulse}, 8'h00);
    chk("t4_valid", {7'd0, move_valid}, 8'h00);
    send(8'hE0, 1'b0, 2'b00); send(8'hF0, 1'b0, 2'b00); send(8'h5A, 1'b0, 2'b00);
    send(8'h29, 1'b0, 2'b00);
    chk("t4_space", {7'd0, start_pulse}, 8'h01);

    // Typematic repeat of W.
    send(8'h1D, 1'b1, 2'b00); send(8'h1D, !FLT, 2'b00); send(8'h1D, !FLT, 2'b00);
    send(8'hF0, 1'b0, 2'b00); send(8'h1D, 1'b0, 2'b00);
    send(8'h1D, 1'b1, 2'b00); send(8'h1D, !FLT, 2'b00);
    chk("t5_count", {5'd0, fifo_count}, FLT ? 8'h02 : 8'h04);
    move_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    move_ready = 1'b0;
    chk("t5_drained", {5'd0, fifo_count}, 8'h00);

    // Reset in the middle of an extended sequence.
    send(8'hE0, 1'b0, 2'b00);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    sb.delete(); exp_ovf = 1'b0;
    send(8'h75, 1'b0, 2'b00);
    chk("t6_no_push", {5'd0, fifo_count}, 8'h00);
    chk("t6_valid", {7'd0, move_valid}, 8'h00);
    send(8'h1D, 1'b1, 2'b00);
    chk("t6_idle", {5'd0, fifo_count}, 8'h01);
    move_ready = 1'b1; tick(); tick(); move_ready = 1'b0;
    chk("t6_drained", {5'd0, fifo_count}, 8'h00);
    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
Sits between PS2_Controller and the game handshake FSM. Parses PS/2 set-2 scan-code bytes (E0 extended prefix, F0 break prefix) into movement commands (WASD or arrow keys) and a start-key pulse. Movement commands are buffered in a small FIFO with a valid/ready handshake, so keypresses that arrive while the FSM is busy drawing or erasing are not lost.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
CW, 3, width of fifo_count; must equal log2(DEPTH)+1.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous active-low reset
ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data valid
ps2_key_data  in  8  received scan-code byte
flush  in  1  synchronous clear of FIFO and parser (driven on externalReset / new game)
move_ready  in  1  consumer accepts head entry this cycle
move_valid  out  1  FIFO non-empty
move_dir  out  2  head entry: 00 up, 01 down, 10 left, 11 right
start_pulse  out  1  one-cycle pulse on Enter (5A) or Space (29) make
overflow  out  1  sticky: a move was dropped because the FIFO was full
fifo_count  out  CW  current occupancy, 0..DEPTH

Behaviour:
- Reset (resetn=0, async): parser in IDLE; FIFO empty; move_valid=0, move_dir=00, start_pulse=0, overflow=0, fifo_count=0; held bits cleared.
- Bytes are sampled only on clk edges where ps2_key_pressed=1. All other cycles leave the parser state unchanged.
- Parser states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0->EXT; F0->BRK; any other byte is a plain make, decoded, then stay IDLE.
  - EXT: E0->EXT; F0->EXT_BRK; other byte is an extended make, decoded, ->IDLE.
  - BRK: F0->BRK; other byte is a plain break ->IDLE.
  - EXT_BRK: F0->EXT_BRK; other byte is an extended break ->IDLE.
- Plain make codes: 1D up, 1B down, 1C left, 23 right, 5A/29 start.
- Extended make codes: 75 up, 72 down, 6B left, 74 right, 5A (keypad Enter) start.
- Unrecognised codes produce no output; the parser still returns to IDLE.
- Break codes never push and never pulse; they only clear held bits (see Optional Feature).
- Direction make: push move_dir into the FIFO on the same edge the completing byte is sampled. move_valid rises on the next cycle (latency 1 from strobe to valid when the FIFO was empty).
- start_pulse: registered; high exactly the cycle after the completing byte's strobe. Never queued.
- FIFO: move_valid = (fifo_count != 0); move_dir shows the head entry (00 when empty).
  - Pop on any edge with move_valid & move_ready. move_ready while empty is ignored.
- Full: a push with count==DEPTH and no simultaneous pop is dropped, sets overflow=1, and leaves the FIFO unchanged.
- Push and pop in the same cycle while full are both accepted; count stays DEPTH.
- Push and pop in the same cycle while empty: the push is stored, the pop is ignored (valid was 0), count becomes 1.
- Pointers wrap modulo DEPTH. fifo_count is updated by +1, -1, or 0 per cycle.
- flush=1 (synchronous, highest priority): FIFO emptied, parser ->IDLE, held bits cleared, overflow cleared. A coincident byte strobe is discarded; start_pulse is 0 the next cycle.
- Reset asserted mid-sequence (e.g. after E0) returns to IDLE; the next byte is parsed as a plain byte.

Optional Feature:
Macro PS2_MOVE_REPEAT_FILTER_EN.
- Defined: a 4-bit held register, one bit per direction shared by the WASD and arrow sources.
  - A make sets the bit. A make arriving while the bit is already set (typematic repeat) does not push.
  - A break of either source key for that direction clears the bit.
  - start_pulse is filtered the same way with its own held bit.
- Undefined: no held state; every make code pushes or pulses, and break codes are simply consumed.

Test Plan:
- Bytes 1D, F0 1D with move_ready=1 -> one entry dir=00; move_valid high 1 cycle after the first strobe, then low; nothing pushed on the break.
- Bytes E0 74, E0 F0 74, E0 6B with move_ready=0 -> fifo_count=2, head dir=11; assert ready one cycle -> head dir=10, count=1.
- DEPTH=4, ready=0, six makes 1C,23,1B,1D,1C,23 -> count=4, overflow=1, entries in order 10,11,01,00; flush -> count=0, overflow=0, move_valid=0 next cycle.
- Full FIFO, ready=1 and make 1B on the same edge -> count stays 4, new tail=01, overflow unchanged.
- Byte 5A, then bytes E0 5A -> two start_pulse cycles of width 1; move_valid stays 0.
- With PS2_MOVE_REPEAT_FILTER_EN: 1D,1D,1D,F0 1D,1D -> exactly 2 pushes of 00. Without the macro: same stimulus -> 4 pushes.
- Reset asserted after E0, then byte 75 after release -> no push (75 is unrecognised as a plain code); the parser is in IDLE.
